// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state type, default data width, majority vote helper.
package uart_pkg;

    localparam int unsigned UART_DATA_W = 8;

    typedef enum logic [2:0] {
        RX_IDLE,
        RX_START,
        RX_DATA,
        RX_PARITY,
        RX_STOP,
        RX_WAIT_IDLE
    } rx_state_t;

    function automatic logic maj3(input logic a, input logic b, input logic c);
        return (a & b) | (a & c) | (b & c);
    endfunction

endpackage

// File: rtl/uart_sync.sv
// N-flop synchronizer for asynchronous UART lines; flops reset to 1 (line idle).
module uart_sync #(
    parameter int unsigned STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ff <= '1;
        end else begin
            ff <= {ff[STAGES-2:0], d};
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx_ctrl.sv
// UART receive frame controller driving an external baud/oversampling generator.
// Optional parity checking is enabled with `define UART_RX_PARITY_EN.
module uart_rx_ctrl
    import uart_pkg::*;
#(
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned DATA_W      = UART_DATA_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              rx,
    input  logic              cfg_stop2,
    output logic              baud_clear,
    input  logic              baud_sample_6th,
    input  logic              baud_sample_8th,
    input  logic              baud_sample_10th,
    input  logic              baud_sample_16th,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ready,
    output logic              frame_err,
    output logic              overrun_err,
    output logic              busy
`ifdef UART_RX_PARITY_EN
    ,
    input  logic              cfg_parity_odd,
    output logic              parity_err
`endif
);

    localparam int unsigned CNT_W = (DATA_W > 1) ? $clog2(DATA_W) : 1;

    rx_state_t         state;
    logic              rx_s;
    logic              v0;
    logic              v1;
    logic              vote;
    logic [DATA_W-1:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              stop2;
    logic              second_stop;
    logic              frame_done;
`ifdef UART_RX_PARITY_EN
    logic              par_bad;
`endif

    uart_sync #(
        .STAGES(SYNC_STAGES)
    ) u_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (rx),
        .q    (rx_s)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            v0 <= 1'b1;
            v1 <= 1'b1;
        end else begin
            if (baud_sample_6th) v0 <= rx_s;
            if (baud_sample_8th) v1 <= rx_s;
        end
    end

    always_comb begin
        vote       = maj3(v0, v1, rx_s);
        baud_clear = (state == RX_IDLE) || (state == RX_WAIT_IDLE);
        busy       = (state != RX_IDLE);
        // A good final stop bit completes the frame at its 10th sample, not at bit end.
        frame_done = (state == RX_STOP) && baud_sample_10th && vote &&
                     (!stop2 || second_stop);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= RX_IDLE;
            rx_valid    <= 1'b0;
            rx_data     <= '0;
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
            shreg       <= '0;
            bit_cnt     <= '0;
            stop2       <= 1'b0;
            second_stop <= 1'b0;
`ifdef UART_RX_PARITY_EN
            par_bad     <= 1'b0;
            parity_err  <= 1'b0;
`endif
        end else begin
            frame_err   <= 1'b0;
            overrun_err <= 1'b0;
`ifdef UART_RX_PARITY_EN
            parity_err  <= 1'b0;
`endif

            if (frame_done) begin
                if (!rx_valid || rx_ready) begin
                    rx_data  <= shreg;
                    rx_valid <= 1'b1;
                end else begin
                    overrun_err <= 1'b1;
                end
`ifdef UART_RX_PARITY_EN
                parity_err <= par_bad;
`endif
            end else if (rx_valid && rx_ready) begin
                rx_valid <= 1'b0;
            end

            case (state)
                RX_IDLE: begin
                    if (!rx_s) begin
                        state       <= RX_START;
                        stop2       <= cfg_stop2;
                        second_stop <= 1'b0;
                    end
                end
                RX_START: begin
                    if (baud_sample_10th && vote) begin
                        state <= RX_IDLE;
                    end else if (baud_sample_16th) begin
                        state   <= RX_DATA;
                        bit_cnt <= '0;
                    end
                end
                RX_DATA: begin
                    if (baud_sample_10th) begin
                        shreg <= {vote, shreg[DATA_W-1:1]};
                    end
                    if (baud_sample_16th) begin
                        if (bit_cnt == CNT_W'(DATA_W - 1)) begin
`ifdef UART_RX_PARITY_EN
                            state <= RX_PARITY;
`else
                            state <= RX_STOP;
`endif
                        end else begin
                            bit_cnt <= bit_cnt + CNT_W'(1);
                        end
                    end
                end
`ifdef UART_RX_PARITY_EN
                RX_PARITY: begin
                    if (baud_sample_10th) begin
                        par_bad <= (vote != ((^shreg) ^ cfg_parity_odd));
                    end
                    if (baud_sample_16th) begin
                        state <= RX_STOP;
                    end
                end
`endif
                RX_STOP: begin
                    if (baud_sample_10th) begin
                        if (!vote) begin
                            frame_err <= 1'b1;
                            state     <= RX_WAIT_IDLE;
                        end else if (!stop2 || second_stop) begin
                            state <= RX_IDLE;
                        end
                    end else if (baud_sample_16th) begin
                        second_stop <= 1'b1;
                    end
                end
                RX_WAIT_IDLE: begin
                    if (rx_s) begin
                        state <= RX_IDLE;
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule
